dmem_bus_ctrl: RTL

DMEM_BUS_CTRL -- requirements
Module: dmem_bus_ctrl

---
 rtl/dmem_bus_ctrl_pkg.sv | 24 ++
 rtl/dmem_bus_ctrl_if.sv | 23 ++
 rtl/dmem_lane_align.sv | 30 +++
 rtl/dmem_bus_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/dmem_bus_ctrl_pkg.sv
// Shared types and constants for the data-memory bus controller.
package dmem_bus_ctrl_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned MASK_W          = DATA_W / 8;
    localparam int unsigned CNT_W           = 10;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Latched bus command, held stable for the whole REQ phase
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] be;
    } bus_cmd_t;

endpackage

// File: rtl/dmem_bus_ctrl_if.sv
// Single-outstanding request/ack memory bus between the controller and a slave.
interface dmem_bus_ctrl_if;
    import dmem_bus_ctrl_pkg::*;

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [MASK_W-1:0] bus_be;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Load alignment: zero unselected bytes, then shift down to the lowest selected lane.
module dmem_lane_align
    import dmem_bus_ctrl_pkg::*;
(
    input  logic [MASK_W-1:0] mask,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] aligned_c
);

    localparam int unsigned IDX_W = $clog2(MASK_W);

    logic [DATA_W-1:0] masked;
    logic [IDX_W-1:0]  low_idx;

    always_comb begin
        masked  = '0;
        low_idx = '0;
        for (int i = 0; i < int'(MASK_W); i++) begin
            masked[8*i +: 8] = mask[i] ? raw[8*i +: 8] : 8'h00;
        end
        // Descending scan leaves the lowest set lane in low_idx
        for (int i = int'(MASK_W) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = IDX_W'(i);
            end
        end
        aligned_c = masked >> {low_idx, 3'b000};
    end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// MEM-stage to memory-bus bridge: one access at a time, stalls the pipeline, times out.
module dmem_bus_ctrl
    import dmem_bus_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memCe,
    input  logic              memWr,
    input  logic              memRr,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [DATA_W-1:0] wtData,
    input  logic [MASK_W-1:0] w_mask,
    input  logic [MASK_W-1:0] r_mask,
    output logic [DATA_W-1:0] rdData,
    output logic              rdValid,
    output logic              stall,
    output logic              bus_err,
    dmem_bus_ctrl_if.master   bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    bus_cmd_t          cmd_q, cmd_d;
    logic              bus_req_q, bus_req_d;
    logic              rd_valid_q, rd_valid_d;
    logic              bus_err_q, bus_err_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic [MASK_W-1:0] sel_mask;
    logic              accept_c;
    logic              illegal_c;
    logic              timeout_hit;
    logic [DATA_W-1:0] aligned_c;

    assign sel_mask    = memWr ? w_mask : r_mask;
    assign accept_c    = memCe && (memWr ^ memRr) && (|sel_mask);
    assign illegal_c   = memCe && memWr && memRr;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    dmem_lane_align u_align (
        .mask      (cmd_q.be),
        .raw       (bus.bus_rdata),
        .aligned_c (aligned_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cmd_q      <= '0;
            bus_req_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            bus_req_q  <= bus_req_d;
            rd_valid_q <= rd_valid_d;
            bus_err_q  <= bus_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c) state_d = ST_REQ;
            ST_REQ:  if (bus.bus_ack || timeout_hit) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values; ack takes priority over timeout
    always_comb begin
        cmd_d      = cmd_q;
        cnt_d      = cnt_q;
        bus_req_d  = 1'b0;
        rd_valid_d = 1'b0;
        bus_err_d  = 1'b0;
        rd_data_d  = rd_data_q;
        stall      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    stall       = 1'b1;
                    cmd_d.we    = memWr;
                    cmd_d.addr  = memAddr & ~ADDR_W'(3);
                    cmd_d.wdata = wtData;
                    cmd_d.be    = sel_mask;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                end else if (illegal_c) begin
                    bus_err_d = 1'b1;
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (bus.bus_ack) begin
                    rd_valid_d = !cmd_q.we;
                    if (!cmd_q.we) rd_data_d = aligned_c;
                end else if (timeout_hit) begin
                    bus_err_d  = 1'b1;
                    rd_valid_d = !cmd_q.we;
                    if (!cmd_q.we) rd_data_d = '0;
                end else begin
                    bus_req_d = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign rdData        = rd_data_q;
    assign rdValid       = rd_valid_q;
    assign bus_err       = bus_err_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = cmd_q.we;
    assign bus.bus_addr  = cmd_q.addr;
    assign bus.bus_wdata = cmd_q.wdata;
    assign bus.bus_be    = cmd_q.be;

endmodule
